// File: rtl/dsp_op_sequencer.sv
// dsp_op_sequencer: request front end for the FB42 fused multiply-add datapath.
// Turns accepted requests into per-mode issue sequences, keeps the mac feedback
// chain alive for back-to-back accumulates, and gathers datapath results into a
// first-word fall-through FIFO that is protected by credit-based back-pressure.
module dsp_op_sequencer #(
    parameter int          N         = 16,
    parameter int          M         = 16,
    parameter int          OUT_LAT   = 1,
    parameter int          RES_DEPTH = 4,
    parameter logic [1:0]  PIPE_CFG  = 2'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_mode,
    input  logic [N-1:0]     req_aa,
    input  logic [M-1:0]     req_bb,
    input  logic [N+M-1:0]   req_cc,
    input  logic             req_acc,
    input  logic [1:0]       req_shamt,
    input  logic             req_shdir,
    output logic             dsp_start,
    output logic [1:0]       dsp_mode,
    output logic             dsp_mac,
    output logic [N-1:0]     dsp_aa,
    output logic [M-1:0]     dsp_bb,
    output logic [N+M-1:0]   dsp_cc,
    output logic [1:0]       dsp_shift_amount,
    output logic             dsp_shift_dir,
    output logic [1:0]       dsp_pipe_stages,
    input  logic [N+M-1:0]   dsp_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N+M-1:0]   rsp_data
);

    localparam int R  = N + M;
    localparam int PW = $clog2(RES_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(RES_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACC = 2'd2
    } state_t;

    // Index of the last issue cycle for a mode (length minus one).
    function automatic logic [1:0] last_idx(input logic [1:0] mode);
        logic [1:0] idx;
        case (mode)
            2'd1:    idx = 2'd1;
            2'd2:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    state_t         state_r, state_nxt_s;
    logic [1:0]     cnt_r, cnt_nxt_s;
    logic           load_req_s, load_pend_s;

    logic [1:0]     dsp_mode_r;
    logic [N-1:0]   dsp_aa_r;
    logic [M-1:0]   dsp_bb_r;
    logic [R-1:0]   dsp_cc_r;
    logic [1:0]     shamt_r;
    logic           shdir_r;
    logic           start_r;
    logic           mac_r;

    logic [1:0]     pend_mode_r;
    logic [N-1:0]   pend_aa_r;
    logic [M-1:0]   pend_bb_r;

    logic [CW-1:0]  outst_r;
    logic [CW-1:0]  fifo_cnt_r;
    logic [PW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [R-1:0]   mem_r [RES_DEPTH];
    logic [R-1:0]   acc_reg_r;

    logic           issue_last_s;
    logic [CW:0]    used_s;
    logic           credit_ok_s;
    logic           req_ready_s;
    logic           accept_s;
    logic [1:0]     req_mode_s;
    logic           chain_s;
    logic           tok_exit_s;
    logic           fifo_empty_s;
    logic           rsp_valid_s;
    logic           pop_s;
    logic           wr_en_s;
    logic           rd_en_s;
    logic [R-1:0]   rsp_data_s;

    // Outstanding ops (accepted, not yet retired) reserve a FIFO slot each, so
    // an op accepted on the last issue cycle can never overrun the FIFO.
    assign issue_last_s = (state_r == ISSUE) && (cnt_r == last_idx(dsp_mode_r));
    assign used_s       = {1'b0, fifo_cnt_r} + {1'b0, outst_r};
    assign credit_ok_s  = (used_s < DEPTH_C);
    assign req_ready_s  = !reset && credit_ok_s && ((state_r == IDLE) || issue_last_s);
    assign accept_s     = req_valid && req_ready_s;
    assign req_mode_s   = (req_mode == 2'd3) ? 2'd0 : req_mode;
    assign chain_s      = accept_s && req_acc && (state_r == ISSUE);

    // Next-state and load decisions for the issue FSM.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        load_req_s  = 1'b0;
        load_pend_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && req_acc) begin
                    state_nxt_s = WAIT_ACC;
                end else if (accept_s) begin
                    state_nxt_s = ISSUE;
                    cnt_nxt_s   = 2'd0;
                    load_req_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (issue_last_s && accept_s) begin
                    state_nxt_s = ISSUE;
                    cnt_nxt_s   = 2'd0;
                    load_req_s  = 1'b1;
                end else if (issue_last_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 2'd0;
                end else begin
                    cnt_nxt_s   = cnt_r + 2'd1;
                end
            end
            WAIT_ACC: begin
                // Only the waiting op itself is still outstanding: the
                // accumulator now holds the last retired result.
                if (outst_r == CNT_ONE) begin
                    state_nxt_s = ISSUE;
                    cnt_nxt_s   = 2'd0;
                    load_pend_s = 1'b1;
                end else begin
                    state_nxt_s = WAIT_ACC;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 2'd0;
            end
        endcase
    end

    // FSM state and issue-cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Datapath control/operand registers, loaded at the start of each issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            dsp_mode_r <= 2'd0;
            dsp_aa_r   <= {N{1'b0}};
            dsp_bb_r   <= {M{1'b0}};
            dsp_cc_r   <= {R{1'b0}};
            shamt_r    <= 2'd0;
            shdir_r    <= 1'b0;
            start_r    <= 1'b0;
            mac_r      <= 1'b0;
        end else if (load_req_s) begin
            dsp_mode_r <= req_mode_s;
            dsp_aa_r   <= req_aa;
            dsp_bb_r   <= req_bb;
            dsp_cc_r   <= req_acc ? {R{1'b0}} : req_cc;
            shamt_r    <= req_acc ? req_shamt : 2'd0;
            shdir_r    <= req_acc ? req_shdir : 1'b0;
            start_r    <= 1'b1;
            mac_r      <= req_acc;
        end else if (load_pend_s) begin
            dsp_mode_r <= pend_mode_r;
            dsp_aa_r   <= pend_aa_r;
            dsp_bb_r   <= pend_bb_r;
            dsp_cc_r   <= acc_reg_r;
            shamt_r    <= 2'd0;
            shdir_r    <= 1'b0;
            start_r    <= 1'b1;
            mac_r      <= 1'b0;
        end else begin
            start_r    <= 1'b0;
            mac_r      <= 1'b0;
        end
    end

    // Operands of an accumulate that must wait for the pipeline to drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_mode_r <= 2'd0;
            pend_aa_r   <= {N{1'b0}};
            pend_bb_r   <= {M{1'b0}};
        end else if (accept_s && req_acc && (state_r == IDLE)) begin
            pend_mode_r <= req_mode_s;
            pend_aa_r   <= req_aa;
            pend_bb_r   <= req_bb;
        end else begin
            pend_mode_r <= pend_mode_r;
        end
    end

    // Result tokens: one per op, launched on its last issue cycle.
    generate
        if (OUT_LAT == 0) begin : g_lat0
            assign tok_exit_s = issue_last_s;
        end else begin : g_latn
            logic [OUT_LAT-1:0] tok_pipe_r;
            // Delay line aligning each token with its dsp_out result.
            always_ff @(posedge clk) begin
                if (reset) begin
                    tok_pipe_r <= {OUT_LAT{1'b0}};
                end else begin
                    tok_pipe_r[0] <= issue_last_s;
                    for (int i = 1; i < OUT_LAT; i++) begin
                        tok_pipe_r[i] <= tok_pipe_r[i-1];
                    end
                end
            end
            assign tok_exit_s = tok_pipe_r[OUT_LAT-1];
        end
    endgenerate

    // Count of accepted ops whose result has not yet reached the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            outst_r <= {CW{1'b0}};
        end else begin
            outst_r <= outst_r + {{(CW-1){1'b0}}, accept_s} - {{(CW-1){1'b0}}, tok_exit_s};
        end
    end

    // Accumulator register: most recently retired result.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg_r <= {R{1'b0}};
        end else if (tok_exit_s) begin
            acc_reg_r <= dsp_out;
        end else begin
            acc_reg_r <= acc_reg_r;
        end
    end

    // A result arriving at an empty FIFO bypasses storage; it is only written
    // if nobody consumes it in the same cycle.
    assign fifo_empty_s = (fifo_cnt_r == {CW{1'b0}});
    assign rsp_valid_s  = !fifo_empty_s || tok_exit_s;
    assign pop_s        = rsp_ready && rsp_valid_s;
    assign wr_en_s      = tok_exit_s && !(fifo_empty_s && pop_s);
    assign rd_en_s      = pop_s && !fifo_empty_s;

    // Result FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            fifo_cnt_r <= {CW{1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= dsp_out;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            fifo_cnt_r <= fifo_cnt_r + {{(CW-1){1'b0}}, wr_en_s} - {{(CW-1){1'b0}}, rd_en_s};
        end
    end

    // Head-of-FIFO selection, falling through to dsp_out when empty.
    always_comb begin
        rsp_data_s = {R{1'b0}};
        if (!fifo_empty_s) begin
            rsp_data_s = mem_r[rd_ptr_r];
        end else if (tok_exit_s) begin
            rsp_data_s = dsp_out;
        end else begin
            rsp_data_s = {R{1'b0}};
        end
    end

    assign req_ready        = req_ready_s;
    assign dsp_start        = start_r;
    assign dsp_mode         = dsp_mode_r;
    assign dsp_mac          = mac_r || chain_s;
    assign dsp_aa           = dsp_aa_r;
    assign dsp_bb           = dsp_bb_r;
    assign dsp_cc           = dsp_cc_r;
    assign dsp_shift_amount = shamt_r;
    assign dsp_shift_dir    = shdir_r;
    assign dsp_pipe_stages  = PIPE_CFG;
    assign rsp_valid        = rsp_valid_s;
    assign rsp_data         = rsp_data_s;

endmodule

// File: doc/dsp_op_sequencer.md
Name: dsp_op_sequencer

Overview:
- Front-end controller for the FB42 fused multiply-add DSP datapath.
- Accepts multiply(-accumulate) operation requests over a valid/ready handshake and drives the datapath control and operand pins for the correct number of issue cycles per mode.
- Keeps the mac/mac_prev feedback chain intact for back-to-back accumulates.
- Collects results into a small FIFO with output valid/ready and credit-based back-pressure.

Parameters:
- N, 16, width of operand A.
- M, 16, width of operand B; result width R = N+M.
- OUT_LAT, 1, cycles from last issue cycle to dsp_out valid (0..3).
- RES_DEPTH, 4, result FIFO entries (power of two, ≥2).
- PIPE_CFG, 0, constant driven on dsp_pipe_stages.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_mode  in  2  0: 1-cycle narrow, 1: 2-cycle N×M/2, 2: 4-cycle signed full; 3 is illegal and treated as 0
- req_aa  in  N  operand A
- req_bb  in  M  operand B
- req_cc  in  R  addend
- req_acc  in  1  accumulate onto the previous op's result
- req_shamt  in  2  feedback shift amount (accumulate only)
- req_shdir  in  1  feedback shift direction
- dsp_start  out  1  datapath start
- dsp_mode  out  2  datapath mode
- dsp_mac  out  1  datapath mac
- dsp_aa  out  N  operand A
- dsp_bb  out  M  operand B
- dsp_cc  out  R  addend
- dsp_shift_amount  out  2  feedback shift amount
- dsp_shift_dir  out  1  feedback shift direction
- dsp_pipe_stages  out  2  constant PIPE_CFG
- dsp_out  in  R  datapath result
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  FIFO head consumed
- rsp_data  out  R  FIFO head

Behaviour:
- Issue length L: mode 0 → 1, mode 1 → 2, mode 2 → 4 cycles.
- FSM states: IDLE, ISSUE, WAIT_ACC.
- Reset: FSM to IDLE, FIFO emptied, in-flight tokens cleared, accumulator register cleared. All outputs 0 except dsp_pipe_stages = PIPE_CFG.
- Reset mid-operation: in-flight results are discarded.
- Credits:
  - credits = RES_DEPTH − FIFO occupancy − in-flight tokens.
  - Acceptance requires credits ≥ 1.
  - A FIFO pop in the same cycle does not add a credit until the next cycle.
- Acceptance:
  - req_ready = credits≥1 AND (state==IDLE OR (state==ISSUE AND last issue cycle)).
  - In WAIT_ACC, req_ready = 0.
- On accept in cycle t: operands, mode, cc, shift, and acc are registered. The first issue cycle is t+1.
- dsp_aa, dsp_bb and dsp_mode are held constant for all L issue cycles.
- dsp_start is high only on the first issue cycle.
- Idle outputs: when no op is issuing, dsp_start = 0 and dsp_mac = 0; operand outputs hold their last values.
- Accumulate chain (back-to-back):
  - Condition: req_acc accepted on the last issue cycle of the previous op.
  - dsp_mac is combinationally high in that accept cycle (Mealy: req_valid & req_ready & req_acc) and high on the new op's first issue cycle.
  - dsp_shift_amount and dsp_shift_dir present the new op's values on its first issue cycle.
  - dsp_cc is don't-care and is driven to 0.
- Broken chain:
  - Condition: req_acc accepted from IDLE, i.e. there is a gap.
  - Enter WAIT_ACC until all in-flight tokens have retired.
  - Then issue with dsp_mac = 0 and dsp_cc = accumulator register, the last retired result.
  - The shift fields are ignored.
  - If no result has retired since reset, the accumulator register is 0.
- Non-accumulate ops: dsp_mac = 0, dsp_cc = req_cc.
- Result capture:
  - A token enters a length-OUT_LAT delay line on each op's last issue cycle. With OUT_LAT = 0, it is captured in that same cycle.
  - When a token exits, dsp_out is pushed to the FIFO and also written to the accumulator register.
- FIFO behaviour:
  - First-word fall-through.
  - Simultaneous push and pop is allowed at any occupancy, including full and empty.
  - Overflow cannot occur because of credits; the bench asserts this.
  - rsp_data is stable while rsp_valid & !rsp_ready.
- Throughput: with rsp_ready held high, consecutive mode-0 ops sustain 1 op/cycle.
- Results emerge in request order.

Test Plan:
- Mode 0, aa=3, bb=5, cc=7, rsp_ready=1 → dsp_start pulses for 1 cycle; rsp_data=22, appearing OUT_LAT+1 cycles after accept.
- Mode 2, aa=16'hFFFD, bb=1000, cc=0 → 4 issue cycles with start only on the first; rsp_data=32'hFFFFF448.
- Mode 2, aa=10, bb=20, cc=5, then back-to-back req_acc=1 mode 2, aa=3, bb=4, shamt=0 → dsp_mac high on the boundary cycle and the next; results 205 then 217.
- Same pair with 3 idle cycles between requests → WAIT_ACC entered; second op issued with dsp_cc=205; result 217.
- rsp_ready=0 with 6 mode-0 requests → exactly RES_DEPTH accepted and req_ready low after that; release → 4 results in order, then the remaining 2 accepted.
- Reset asserted on the 2nd issue cycle of a mode-2 op → next cycle all outputs 0, rsp_valid=0, FIFO empty; a new mode-0 op afterwards completes normally.
